// File: rtl/paws_reset_pkg.sv
// Shared types and constants for the PAWS reset sequencer.
package paws_reset_pkg;

    // Sequencer states, in the order the resets are released.
    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLD,
        REL_VIO,
        REL_CACHE,
        RUN
    } seqState_e;

    // Width and saturation value of the abort counter.
    localparam int RESTART_W = 8;
    localparam logic [RESTART_W-1:0] RESTART_MAX = '1;

    // Increment that sticks at the saturation value instead of wrapping.
    function automatic logic [RESTART_W-1:0] satInc(input logic [RESTART_W-1:0] v);
        return (v == RESTART_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/paws_reset_sequencer_sync.sv
// N-stage single-bit synchronizer with asynchronous active-high clear.
module paws_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain; the last flop is the
    // metastability-settled copy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/paws_reset_sequencer.sv
// Staged reset release for the PAWS-CPU: video IO, then cache, then CPU, once
// the PLL lock has been stable for HOLD_CYCLES. Any lock loss (and, when built
// with PAWS_RSTSEQ_BTN_EN, a debounced button press) restarts the sequence.
module paws_reset_sequencer
    import paws_reset_pkg::*;
#(
    parameter int HOLD_CYCLES     = 65535,
    parameter int STAGE_GAP       = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1023
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pll_locked,
    input  logic                 btn_reset,
    output logic                 rst_vio,
    output logic                 rst_cache,
    output logic                 rst_cpu,
    output logic                 ready,
    output logic [RESTART_W-1:0] restart_count
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(STAGE_GAP - 1);

    logic lockS;
    logic btnEvent;
    logic abortReq;

    seqState_e            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [RESTART_W-1:0] restartCnt_q, restartCnt_d;
    logic                 rstVio_q, rstVio_d;
    logic                 rstCache_q, rstCache_d;
    logic                 rstCpu_q, rstCpu_d;
    logic                 ready_q, ready_d;

    paws_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lockSync (
        .clock (clock),
        .reset (reset),
        .d_i   (pll_locked),
        .q_o   (lockS)
    );

`ifdef PAWS_RSTSEQ_BTN_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);

    logic            btnS;
    logic [DB_W-1:0] dbCnt_q;

    paws_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_btnSync (
        .clock (clock),
        .reset (reset),
        .d_i   (btn_reset),
        .q_o   (btnS)
    );

    // Count consecutive high cycles of the button, holding at the threshold so
    // the event persists for as long as the button stays pressed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dbCnt_q <= '0;
        end else if (!btnS) begin
            dbCnt_q <= '0;
        end else if (dbCnt_q != DB_LAST) begin
            dbCnt_q <= dbCnt_q + 1'b1;
        end
    end

    assign btnEvent = (dbCnt_q == DB_LAST);
`else
    logic unusedBtn;

    assign unusedBtn = btn_reset & (DEBOUNCE_CYCLES > 0);
    assign btnEvent  = 1'b0;
`endif

    assign abortReq = !lockS || btnEvent;

    // Next-state, stage counter and abort counter; output flops are derived from
    // the next state so every reset line changes on the same edge as the FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        restartCnt_d = restartCnt_q;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lockS && !btnEvent) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (abortReq) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = REL_VIO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            REL_VIO, REL_CACHE: begin
                if (abortReq) begin
                    state_d      = WAIT_LOCK;
                    cnt_d        = '0;
                    restartCnt_d = satInc(restartCnt_q);
                end else if (cnt_q == GAP_LAST) begin
                    state_d = (state_q == REL_VIO) ? REL_CACHE : RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (abortReq) begin
                    state_d      = WAIT_LOCK;
                    restartCnt_d = satInc(restartCnt_q);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        rstVio_d   = (state_d == WAIT_LOCK) || (state_d == HOLD);
        rstCache_d = !((state_d == REL_CACHE) || (state_d == RUN));
        rstCpu_d   = (state_d != RUN);
        ready_d    = (state_d == RUN);
    end

    // State, counters and registered outputs; the asynchronous reset forces every
    // reset line high immediately, independent of the clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            restartCnt_q <= '0;
            rstVio_q     <= 1'b1;
            rstCache_q   <= 1'b1;
            rstCpu_q     <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            restartCnt_q <= restartCnt_d;
            rstVio_q     <= rstVio_d;
            rstCache_q   <= rstCache_d;
            rstCpu_q     <= rstCpu_d;
            ready_q      <= ready_d;
        end
    end

    assign rst_vio       = rstVio_q;
    assign rst_cache     = rstCache_q;
    assign rst_cpu       = rstCpu_q;
    assign ready         = ready_q;
    assign restart_count = restartCnt_q;

endmodule

// File: tb/tb_paws_reset_sequencer.sv
// Scoreboard bench for paws_reset_sequencer. Expectations are queued against an
// edge number; a negedge monitor pops and compares them. Build with
// PAWS_RSTSEQ_BTN_EN to exercise the debounced button path.
module tb_paws_reset_sequencer;

    localparam logic [3:0] O_RST   = 4'b1110;
    localparam logic [3:0] O_VIO   = 4'b0110;
    localparam logic [3:0] O_CACHE = 4'b0010;
    localparam logic [3:0] O_RUN   = 4'b0001;

    typedef struct {
        int         edgeNum;
        logic [3:0] outs;
        logic [7:0] cnt;
        string      tag;
    } expItem_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       btn_reset = 1'b0;
    logic       rst_vio;
    logic       rst_cache;
    logic       rst_cpu;
    logic       ready;
    logic [7:0] restart_count;

    int         edgeCnt = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] expCnt = 8'd0;
    expItem_t   sbQ[$];

    paws_reset_sequencer #(
        .HOLD_CYCLES     (8),
        .STAGE_GAP       (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .btn_reset     (btn_reset),
        .rst_vio       (rst_vio),
        .rst_cache     (rst_cache),
        .rst_cpu       (rst_cpu),
        .ready         (ready),
        .restart_count (restart_count)
    );

    // 100 MHz-style bench clock; only relative edges matter.
    always #5 clock = ~clock;

    // Edge counter used to timestamp expectations.
    always @(posedge clock) edgeCnt <= edgeCnt + 1;

    task automatic pushExp(input int e, input logic [3:0] o, input logic [7:0] c, input string tag);
        expItem_t it;
        it.edgeNum = e;
        it.outs    = o;
        it.cnt     = c;
        it.tag     = tag;
        sbQ.push_back(it);
    endtask

    // Expected release staircase for a sequence whose first lock sample is e0.
    task automatic pushSeq(input int e0, input logic [7:0] c, input string tag);
        pushExp(e0 + 9,  O_RST,   c, {tag, "_hold"});
        pushExp(e0 + 10, O_VIO,   c, {tag, "_vio_rel"});
        pushExp(e0 + 13, O_VIO,   c, {tag, "_vio_gap"});
        pushExp(e0 + 14, O_CACHE, c, {tag, "_cache_rel"});
        pushExp(e0 + 17, O_CACHE, c, {tag, "_cache_gap"});
        pushExp(e0 + 18, O_RUN,   c, {tag, "_cpu_rel"});
    endtask

    task automatic runTo(input int e);
        while (edgeCnt < e) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Compare due scoreboard entries and the release-order invariant.
    task automatic checkOutput();
        logic [3:0] act;
        act = {rst_vio, rst_cache, rst_cpu, ready};
        checks++;
        if ((!rst_cpu && (rst_cache || rst_vio)) || (!rst_cache && rst_vio) || (ready != !rst_cpu)) begin
            errors++;
            $display("[TB] FAIL order_invariant edge=%0d got vio/cache/cpu/ready=%b", edgeCnt, act);
        end
        for (int i = sbQ.size() - 1; i >= 0; i--) begin
            if (sbQ[i].edgeNum <= edgeCnt) begin
                checks++;
                if (sbQ[i].edgeNum != edgeCnt) begin
                    errors++;
                    $display("[TB] FAIL %s stale edge=%0d wanted edge=%0d", sbQ[i].tag, edgeCnt, sbQ[i].edgeNum);
                end else if (act !== sbQ[i].outs || restart_count !== sbQ[i].cnt) begin
                    errors++;
                    $display("[TB] FAIL %s edge=%0d got outs=%b cnt=%0d expected outs=%b cnt=%0d",
                             sbQ[i].tag, edgeCnt, act, restart_count, sbQ[i].outs, sbQ[i].cnt);
                end
                sbQ.delete(i);
            end
        end
    endtask

    always @(negedge clock) checkOutput();

    task automatic applyStimulus();
        int k;
        int e0;
        int e1;

        // Reset state
        pushExp(2, O_RST, 8'd0, "reset_state");
        runTo(3);
        reset = 1'b0;

        // Power-up sequence
        pll_locked = 1'b1;
        e0 = edgeCnt + 1;
        pushSeq(e0, expCnt, "powerup");
        runTo(e0 + 18);

        // Lock loss in RUN
        k = edgeCnt;
        pushExp(k + 2, O_RUN, expCnt, "lossrun_pre");
        expCnt = expCnt + 8'd1;
        pushExp(k + 3, O_RST, expCnt, "lossrun_abort");
        pll_locked = 1'b0;
        runTo(k + 5);

        // Lock glitch during HOLD at counter 5
        pll_locked = 1'b1;
        e0 = edgeCnt + 1;
        pushExp(e0 + 7,  O_RST, expCnt, "glitch_inhold");
        pushExp(e0 + 10, O_RST, expCnt, "glitch_norelease");
        runTo(e0 + 7);
        pll_locked = 1'b0;
        runTo(e0 + 10);
        pll_locked = 1'b1;
        e1 = edgeCnt + 1;
        pushSeq(e1, expCnt, "relock");
        runTo(e1 + 18);

        // Short button press
        k = edgeCnt;
        pushExp(k + 12, O_RUN, expCnt, "btn_short");
        btn_reset = 1'b1;
        runTo(k + 4);
        btn_reset = 1'b0;
        runTo(k + 12);

        // Six-cycle button press
        k = edgeCnt;
`ifdef PAWS_RSTSEQ_BTN_EN
        pushExp(k + 7, O_RUN, expCnt, "btn6_pre");
        expCnt = expCnt + 8'd1;
        pushExp(k + 8, O_RST, expCnt, "btn6_abort");
        pushSeq(k + 8, expCnt, "btn6_reseq");
        btn_reset = 1'b1;
        runTo(k + 6);
        btn_reset = 1'b0;
        runTo(k + 26);
`else
        pushExp(k + 8,  O_RUN, expCnt, "btn6_ignored");
        pushExp(k + 20, O_RUN, expCnt, "btn6_ignored_late");
        btn_reset = 1'b1;
        runTo(k + 6);
        btn_reset = 1'b0;
        runTo(k + 20);
`endif

        // Held button
        k = edgeCnt;
`ifdef PAWS_RSTSEQ_BTN_EN
        expCnt = expCnt + 8'd1;
        pushExp(k + 8,  O_RST, expCnt, "btnhold_abort");
        pushExp(k + 25, O_RST, expCnt, "btnhold_wait");
        pushSeq(k + 32, expCnt, "btnhold_reseq");
        btn_reset = 1'b1;
        runTo(k + 30);
        btn_reset = 1'b0;
        runTo(k + 50);
`else
        pushExp(k + 8,  O_RUN, expCnt, "btnhold_ignored");
        pushExp(k + 25, O_RUN, expCnt, "btnhold_ignored_late");
        btn_reset = 1'b1;
        runTo(k + 30);
        btn_reset = 1'b0;
        runTo(k + 32);
`endif

        // Saturation of the abort counter
        for (int n = 0; n < 300; n++) begin
            k = edgeCnt;
            expCnt = (expCnt == 8'hFF) ? 8'hFF : expCnt + 8'd1;
            pushExp(k + 3, O_RST, expCnt, "sat_abort");
            pll_locked = 1'b0;
            runTo(k + 4);
            pll_locked = 1'b1;
            e0 = edgeCnt + 1;
            pushExp(e0 + 18, O_RUN, expCnt, "sat_run");
            runTo(e0 + 18);
        end
        pushExp(edgeCnt + 1, O_RUN, 8'hFF, "sat_value");
        runTo(edgeCnt + 1);

        // Asynchronous reset pulse in REL_CACHE
        k = edgeCnt;
        pushExp(k + 3, O_RST, 8'hFF, "prereset_abort");
        pll_locked = 1'b0;
        runTo(k + 4);
        pll_locked = 1'b1;
        e0 = edgeCnt + 1;
        pushExp(e0 + 14, O_CACHE, 8'hFF, "prereset_cache");
        pushExp(e0 + 15, O_RST,   8'd0,  "async_reset");
        runTo(e0 + 15);
        reset = 1'b1;
        runTo(e0 + 17);
        reset = 1'b0;
        e1 = edgeCnt + 1;
        pushSeq(e1, 8'd0, "postreset");
        runTo(e1 + 20);
    endtask

    initial begin
        applyStimulus();
        runTo(edgeCnt + 2);
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_expectations got %0d left expected 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
